instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage sitting directly downstream of the program counter: samples the current PC, issues a single-outstanding instruction-memory read, and holds the returned word with its PC for the decode stage under a valid/ready handshake. It drives the program counter's count-enable with a one-cycle advance pulse per accepted fetch. It also discards in-flight or held work when a redirect (jump/branch write to the PC) is signalled.

## Interface
- ADDR_WIDTH, 32, width of PC and memory address
- DATA_WIDTH, 32, instruction word width
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- enable  in  1  fetch permitted when high
- pcIn  in  ADDR_WIDTH  current program counter value (PC dataOut)
- pcAdvance  out  1  to PC countEnable; high for exactly the cycle a fetch is accepted (PC += 4 at that edge)
- flush  in  1  redirect: PC is being written this cycle; all in-flight/held work is discarded
- memReq  out  1  read request, held until memAck
- memAddr  out  ADDR_WIDTH  read address, stable while memReq high
- memAck  in  1  memory returns memData this cycle
- memData  in  DATA_WIDTH  instruction word, valid when memAck
- instrValid  out  1  instrOut/instrPc valid for decode
- instrOut  out  DATA_WIDTH  fetched instruction
- instrPc  out  ADDR_WIDTH  address instrOut was fetched from
- instrReady  in  1  decode accepts when instrValid & instrReady
- misaligned  out  1  fetch fault: pcIn[1:0] != 0 at launch

## Operation
- States: IDLE, REQ, FULL, FAULT. Reset (reset low): state IDLE; memReq, memAddr, instrValid, instrOut, instrPc, misaligned, internal drop flag all 0. pcAdvance is 0 in reset.
- All outputs registered except pcAdvance = (state==REQ) & memAck & !flush & !drop.
- IDLE: if enable & !flush: pcIn[1:0]!=0 -> FAULT (misaligned<=1); else memAddr<=pcIn, memReq<=1 -> REQ. Otherwise stay.
- REQ: memReq held high, memAddr stable; no abort of an issued request.
  - memAck & !flush & !drop: instrOut<=memData, instrPc<=memAddr, instrValid<=1, memReq<=0 -> FULL; pcAdvance high this cycle.
  - memAck & (flush | drop): data discarded, no pcAdvance, memReq<=0, drop<=0 -> IDLE.
  - !memAck & flush: drop<=1, stay REQ.
- FULL: instrValid held with stable instrOut/instrPc until handshake.
  - flush: instrValid<=0 -> IDLE (flush wins over instrReady).
  - instrReady & enable & pcIn aligned: instrValid<=0, memAddr<=pcIn, memReq<=1 -> REQ.
  - instrReady & enable & pcIn misaligned: instrValid<=0, misaligned<=1 -> FAULT.
  - instrReady & !enable: instrValid<=0 -> IDLE.
- FAULT: memReq=0, instrValid=0, misaligned=1; leave only on flush -> IDLE, misaligned<=0.
- Deasserting enable never cancels a request in REQ nor drops a held instruction in FULL.

## Timing
- Latency pcIn sampled -> instrValid: memory latency (cycles from memReq to memAck, min 0 extra) + 1 cycle.
- With memAck in first REQ cycle and instrReady constant 1: one instruction every 2 cycles.
- pcAdvance asserted in the memAck cycle; pcIn shows PC+4 from the next cycle, before FULL can relaunch.
- flush in cycle N: no pcAdvance in N; first launch from the redirected pcIn no earlier than N+1 (IDLE), or after the pending memAck if in REQ.
- Reset asserted mid-REQ: memReq drops asynchronously; a later memAck in reset or IDLE is ignored.
- Address arithmetic: none internally; alignment check on pcIn[1:0] only.

## Test plan
- Reset low with memAck=1, memData=0xFFFFFFFF -> all outputs 0, state IDLE; release, enable=1, pcIn=0 -> memReq=1, memAddr=0 next cycle.
- pcIn=0x100, memAck 2 cycles after memReq with memData=0x00500093 -> instrValid=1, instrOut=0x00500093, instrPc=0x100 one cycle after ack; pcAdvance single-cycle pulse on ack.
- instrReady=0 for 5 cycles in FULL -> instrOut/instrPc stable, memReq=0, pcAdvance=0; instrReady=1 -> new request at pcIn=0x104.
- flush while REQ awaits ack, ack arrives 3 cycles later with 0xDEADBEEF -> instrValid never rises, no pcAdvance, next memAddr = new pcIn 0x200.
- pcIn=0x102 at launch -> misaligned=1, memReq stays 0; held until flush, then cleared and fetch resumes at aligned pcIn.
- 4 back-to-back fetches, memAck immediate, instrReady=1, PC model counting from 0x0 -> instrPc 0x0,0x4,0x8,0xC every 2 cycles, exactly 4 pcAdvance pulses.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Single-outstanding instruction fetch stage between PC and decode.
// Revision : 1.0
// ============================================================================
module instruction_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] pcIn,
    output logic                  pcAdvance,
    input  logic                  flush,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic                  memAck,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  instrValid,
    output logic [DATA_WIDTH-1:0] instrOut,
    output logic [ADDR_WIDTH-1:0] instrPc,
    input  logic                  instrReady,
    output logic                  misaligned
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FULL  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                r_state,      w_nextState;
    logic                  r_memReq,     w_memReq;
    logic [ADDR_WIDTH-1:0] r_memAddr,    w_memAddr;
    logic                  r_instrValid, w_instrValid;
    logic [DATA_WIDTH-1:0] r_instrOut,   w_instrOut;
    logic [ADDR_WIDTH-1:0] r_instrPc,    w_instrPc;
    logic                  r_misaligned, w_misaligned;
    logic                  r_drop,       w_drop;
    logic                  w_pcAligned;

    assign w_pcAligned = (pcIn[1:0] == 2'b00);
    assign pcAdvance   = (r_state == REQ) & memAck & ~flush & ~r_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_memReq     <= 1'b0;
            r_memAddr    <= '0;
            r_instrValid <= 1'b0;
            r_instrOut   <= '0;
            r_instrPc    <= '0;
            r_misaligned <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_memReq     <= w_memReq;
            r_memAddr    <= w_memAddr;
            r_instrValid <= w_instrValid;
            r_instrOut   <= w_instrOut;
            r_instrPc    <= w_instrPc;
            r_misaligned <= w_misaligned;
            r_drop       <= w_drop;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_memReq     = r_memReq;
        w_memAddr    = r_memAddr;
        w_instrValid = r_instrValid;
        w_instrOut   = r_instrOut;
        w_instrPc    = r_instrPc;
        w_misaligned = r_misaligned;
        w_drop       = r_drop;
        case (r_state)
            IDLE: begin
                if (enable && !flush) begin
                    if (!w_pcAligned) begin
                        w_misaligned = 1'b1;
                        w_nextState  = FAULT;
                    end else begin
                        w_memAddr   = pcIn;
                        w_memReq    = 1'b1;
                        w_nextState = REQ;
                    end
                end
            end
            REQ: begin
                // An issued read cannot be aborted; a redirect only marks it for discard.
                if (memAck) begin
                    w_memReq = 1'b0;
                    if (!flush && !r_drop) begin
                        w_instrOut   = memData;
                        w_instrPc    = r_memAddr;
                        w_instrValid = 1'b1;
                        w_nextState  = FULL;
                    end else begin
                        w_drop      = 1'b0;
                        w_nextState = IDLE;
                    end
                end else if (flush) begin
                    w_drop = 1'b1;
                end
            end
            FULL: begin
                if (flush) begin
                    w_instrValid = 1'b0;
                    w_nextState  = IDLE;
                end else if (instrReady) begin
                    w_instrValid = 1'b0;
                    if (!enable) begin
                        w_nextState = IDLE;
                    end else if (!w_pcAligned) begin
                        w_misaligned = 1'b1;
                        w_nextState  = FAULT;
                    end else begin
                        w_memAddr   = pcIn;
                        w_memReq    = 1'b1;
                        w_nextState = REQ;
                    end
                end
            end
            FAULT: begin
                if (flush) begin
                    w_misaligned = 1'b0;
                    w_nextState  = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign memReq     = r_memReq;
    assign memAddr    = r_memAddr;
    assign instrValid = r_instrValid;
    assign instrOut   = r_instrOut;
    assign instrPc    = r_instrPc;
    assign misaligned = r_misaligned;

endmodule
`default_nettype wire
